// File: rtl/shift_seq.sv
// Multi-cycle MIX shift sequencer: one byte (or one bit) step per cycle on the
// {A,X} working register, with the registered result published on completion.
module shift_seq #(
  parameter int BYTE_BITS = 6,
  parameter int BYTES     = 5,
  parameter int M_WIDTH   = 12
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [BYTE_BITS*BYTES-1:0]        ina,
  input  logic [BYTE_BITS*BYTES-1:0]        inx,
  input  logic [2:0]                        field,
  input  logic [M_WIDTH-1:0]                m,
  output logic [2*BYTE_BITS*BYTES-1:0]      out,
  output logic                              busy,
  output logic                              done
);

  localparam int W     = BYTE_BITS * BYTES;
  localparam int W2    = 2 * W;
  localparam int CNT_W = $clog2(W2 + 1);

  localparam logic [31:0] LIM_A  = 32'(BYTES);
  localparam logic [31:0] LIM_AX = 32'(2 * BYTES);
  localparam logic [31:0] LIM_B  = 32'(W2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [W2-1:0]      work_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2:0]         field_r;
  logic [31:0]        m_ext_s;
  logic [31:0]        n_wide_s;
  logic [CNT_W-1:0]   n_s;
  logic               accept_s;

  // One shift/rotate step of the working register for the latched op.
  function automatic logic [W2-1:0] step_fn(input logic [2:0] f, input logic [W2-1:0] w);
    logic [W-1:0] a_v;
    logic [W-1:0] x_v;
    a_v = w[W2-1:W];
    x_v = w[W-1:0];
    case (f)
      3'd0:    step_fn = {a_v << BYTE_BITS, x_v};
      3'd1:    step_fn = {a_v >> BYTE_BITS, x_v};
      3'd2:    step_fn = w << BYTE_BITS;
      3'd3:    step_fn = w >> BYTE_BITS;
      3'd4:    step_fn = (w << BYTE_BITS) | (w >> (W2 - BYTE_BITS));
      3'd5:    step_fn = (w >> BYTE_BITS) | (w << (W2 - BYTE_BITS));
      3'd6:    step_fn = w << 1;
      3'd7:    step_fn = w >> 1;
      default: step_fn = w;
    endcase
  endfunction

  assign m_ext_s  = 32'(m);
  assign n_s      = CNT_W'(n_wide_s);
  // done still high means the FSM has only just returned to IDLE; hold off one cycle
  assign accept_s = (state_r == IDLE) && start && !done;

  // Effective step count: saturate byte/bit shifts, reduce rotations modulo the word.
  always_comb begin
    n_wide_s = 32'd0;
    case (field)
      3'd0, 3'd1: n_wide_s = (m_ext_s > LIM_A)  ? LIM_A  : m_ext_s;
      3'd2, 3'd3: n_wide_s = (m_ext_s > LIM_AX) ? LIM_AX : m_ext_s;
      3'd4, 3'd5: n_wide_s = m_ext_s % LIM_AX;
      3'd6, 3'd7: n_wide_s = (m_ext_s > LIM_B)  ? LIM_B  : m_ext_s;
      default:    n_wide_s = 32'd0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (n_s != '0) begin
            state_next_s = SHIFT;
          end else begin
            state_next_s = FINISH;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r == CNT_W'(1)) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = SHIFT;
        end
      end
      FINISH:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath: latch operands, step the working register, publish the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work_r  <= '0;
      cnt_r   <= '0;
      field_r <= 3'd0;
      out     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            work_r  <= {ina, inx};
            field_r <= field;
            cnt_r   <= n_s;
            busy    <= 1'b1;
          end
        end
        SHIFT: begin
          work_r <= step_fn(field_r, work_r);
          cnt_r  <= cnt_r - CNT_W'(1);
        end
        FINISH: begin
          out  <= work_r;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: the driver queues whole-operation expectations,
// a done-triggered monitor checks result and completion cycle.
module tb_shift_seq;

  localparam int W = 30;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   ina;
  logic [W-1:0]   inx;
  logic [2:0]     field;
  logic [11:0]    m;
  logic [2*W-1:0] out;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [2*W-1:0] o;
    int             t;
  } exp_t;
  exp_t sb[$];

  localparam logic [W-1:0] A0 = 30'o0102030405;
  localparam logic [W-1:0] X0 = 30'o0607101112;

  shift_seq #(.BYTE_BITS(6), .BYTES(5), .M_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .start(start), .ina(ina), .inx(inx),
    .field(field), .m(m), .out(out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Number of steps the operation takes, straight from the op definitions.
  function automatic int eff_n(input logic [2:0] f, input int mm);
    case (f)
      3'd0, 3'd1: return (mm < 5)  ? mm : 5;
      3'd2, 3'd3: return (mm < 10) ? mm : 10;
      3'd4, 3'd5: return mm % 10;
      default:    return (mm < 60) ? mm : 60;
    endcase
  endfunction

  // Whole-operation result computed in one go.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] x,
                                           input logic [2:0] f, input int n);
    logic [2*W-1:0] w;
    logic [W-1:0]   ar;
    int             r;
    w = {a, x};
    r = 6 * n;
    case (f)
      3'd0: begin ar = a << r; return {ar, x}; end
      3'd1: begin ar = a >> r; return {ar, x}; end
      3'd2: return w << r;
      3'd3: return w >> r;
      3'd4: return (w << r) | (w >> (60 - r));
      3'd5: return (w >> r) | (w << (60 - r));
      3'd6: return w << n;
      default: return w >> n;
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b0 && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        e = sb.pop_front();
        check("out", out, e.o);
        check("done_cycle", cyc, e.t);
        check("busy_at_done", busy, 0);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] x, input logic [2:0] f,
                        input int mm, input logic [2*W-1:0] exp_o, input int n, input bit glitch);
    int t;
    @(negedge clk);
    ina = a; inx = x; field = f; m = 12'(mm); start = 1'b1;
    sb.push_back('{o: exp_o, t: cyc + 1 + n + 1});
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    if (glitch) begin
      ina = ~a; inx = $urandom; field = 3'($urandom); m = 12'($urandom); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=pending expected=done");
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_rand(input bit glitch);
    logic [W-1:0] a, x;
    logic [2:0]   f;
    int           mm, n;
    a  = $urandom;
    x  = $urandom;
    f  = 3'($urandom);
    mm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 12);
    n  = eff_n(f, mm);
    run_op(a, x, f, mm, model(a, x, f, n), n, glitch);
  endtask

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; ina = '0; inx = '0; field = 3'd0; m = 12'd0;
    @(negedge clk);
    check("reset_out", out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;

    run_op(A0, X0, 3'd0, 2, {30'o0304050000, X0}, 2, 1'b0);
    run_op(A0, X0, 3'd3, 1, {30'o0001020304, 30'o0506071011}, 1, 1'b0);
    run_op(A0, X0, 3'd4, 12, {30'o0304050607, 30'o1011120102}, 2, 1'b0);
    run_op(A0, X0, 3'd1, 7, {30'o0, X0}, 5, 1'b0);
    run_op(A0, X0, 3'd5, 0, {A0, X0}, 0, 1'b0);
    run_op(A0, X0, 3'd2, 0, {A0, X0}, 0, 1'b1);
    run_op(30'o0, 30'o1, 3'd6, 3, {30'o0, 30'o10}, 3, 1'b0);
    run_op(A0, X0, 3'd7, 4095, 60'o0, 60, 1'b0);
    run_op(A0, X0, 3'd2, 11, 60'o0, 10, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_rand(i[0]);
    end

    // start raised in the done cycle must be dropped
    @(negedge clk);
    ina = A0; inx = X0; field = 3'd0; m = 12'd1; start = 1'b1;
    sb.push_back('{o: {30'o0203040500, X0}, t: cyc + 3});
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_wait actual=0 expected=1");
      sb.delete();
    end
    ina = X0; field = 3'd7; m = 12'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", busy, 0);
    repeat (8) @(negedge clk);

    // reset in mid-operation aborts with no done
    ina = A0; inx = X0; field = 3'd3; m = 12'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_out", out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("abort_stays_idle", busy, 0);
    run_op(A0, X0, 3'd0, 1, {30'o0203040500, X0}, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq.md
SHIFT_SEQ -- requirements
Module: shift_seq

Interface
REQ-001 The block SHALL have parameter BYTE_BITS, default 6, giving bits per MIX byte.
REQ-002 The block SHALL have parameter BYTES, default 5, giving bytes per word; W = BYTE_BITS*BYTES.
REQ-003 The block SHALL have parameter M_WIDTH, default 12, giving the width of the shift-count operand.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-007 The block SHALL have ports ina and inx, input, W each, the rA and rX magnitudes (sign handled upstream).
REQ-008 The block SHALL have port field, input, 3, the op select: 0 SLA, 1 SRA, 2 SLAX, 3 SRAX, 4 SLC, 5 SRC, 6 SLB, 7 SRB.
REQ-009 The block SHALL have port m, input, M_WIDTH, the unsigned shift count (negative M rejected upstream).
REQ-010 The block SHALL have port out, output, 2W, the result {A,X}, registered.
REQ-011 The block SHALL have port busy, output, 1, high from the edge accepting start until the edge that raises done.
REQ-012 The block SHALL have port done, output, 1, a one-cycle completion pulse.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SHIFT and FINISH.
REQ-014 At the start edge in IDLE it SHALL latch {ina,inx}, field and the effective count N; it SHALL go to SHIFT if N>0, else to FINISH.
REQ-015 N SHALL be min(m,BYTES) for SLA/SRA, min(m,2*BYTES) for SLAX/SRAX, m mod (2*BYTES) for SLC/SRC, and min(m,2W) for SLB/SRB.
REQ-016 Each SHIFT cycle SHALL perform one step and decrement N; the step after which N reaches 0 SHALL move the machine to FINISH.
REQ-017 A step SHALL be one byte (BYTE_BITS bits) for fields 0-5 and one bit for fields 6-7.
REQ-018 SLA/SRA SHALL shift A only with zero fill and leave X unchanged.
REQ-019 SLAX/SRAX/SLB/SRB SHALL shift the 2W-bit {A,X} with zero fill.
REQ-020 SLC/SRC SHALL rotate {A,X}, bits leaving one end entering the other.
REQ-021 In FINISH the block SHALL copy the working register to out, pulse done for exactly one cycle, clear busy, and return to IDLE.
REQ-022 Latency SHALL be N+2 edges from the start edge to done high, and done SHALL be observed high in the cycle after edge k+N+1, where k is the start edge.
REQ-023 out SHALL hold its value until the next FINISH; intermediate steps SHALL NOT be visible on out.
REQ-024 start while busy SHALL be ignored, with no effect on the operation in flight.
REQ-025 start in the same cycle as done SHALL be ignored; a new start is accepted from the following IDLE cycle.
REQ-026 Saturated counts SHALL yield all-zero shifted portions: for SLA/SRA with m>=5 the result is A=0; for SLAX/SRAX with m>=10 the result is {A,X}=0.

Reset
REQ-027 Reset SHALL, asynchronously, force state IDLE, out=0, busy=0, done=0, and clear the working register and count.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no done pulse; after reset releases, the next start SHALL run normally.

Verification (W=30, octal, two digits per byte; A=0102030405, X=0607101112 unless stated)
REQ-029 SLA, m=2 -> out A=0304050000, X=0607101112; done 4 edges after start; busy high 3 cycles.
REQ-030 SRAX m=1 -> out 0001020304 0506071011. SLC m=12 (N=2) -> out 0304050607 1011120102, done 4 edges after start.
REQ-031 SRA m=7 (N=5) -> A=0, X unchanged, done 7 edges after start. m=0 with any field -> out equals inputs, done 2 edges after start.
REQ-032 SLB m=3 with A=0, X=1 -> out X=10 (octal), A=0. SRB m=4095 -> out all zeros after 60 steps.
REQ-033 Start SRAX m=9; on the third SHIFT cycle pulse start again, then assert reset -> out=0, busy=0, no done. Then start SLA m=1 -> out A=0203040500, X=0607101112.
